// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Valid/ready instruction-word stream feeding the program loader.
//               The master drives words; the slave (loader) drives s_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
    parameter int WIDTH = 32
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Streams instruction words into consecutive
//               instruction-memory addresses while holding the core in reset,
//               then releases the core. Tracks word count, checksum and the
//               number of _check (opcode 6'b111111) instructions loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start,
    program_loader_if.slave       s,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [WIDTH-1:0]      checksum,
    output logic [ADDR_WIDTH:0]   check_count
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_FINISH = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_ERROR  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_PTR_MAX = '1;
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [5:0]            c_CHECK_OP = 6'b111111;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  w_accept;
    logic                  w_is_check;

    assign s.s_ready  = (r_state == c_LOAD);
    assign w_accept   = s.s_valid && (r_state == c_LOAD);
    assign w_is_check = (s.s_data[WIDTH-1 -: 6] == c_CHECK_OP);

    // Loader FSM: sequencing, memory write port, core reset and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_rst     <= 1'b1;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            word_count  <= '0;
            checksum    <= '0;
            check_count <= '0;
        end else begin
            // Write strobe is a one-cycle pulse following each accept.
            imem_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_LOAD;
                        r_ptr       <= '0;
                        word_count  <= '0;
                        checksum    <= '0;
                        check_count <= '0;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_ptr;
                        imem_wdata <= s.s_data;
                        r_ptr      <= r_ptr + 1'b1;
                        word_count <= word_count + c_CNT_ONE;
                        checksum   <= checksum + s.s_data;
                        if (w_is_check) begin
                            check_count <= check_count + c_CNT_ONE;
                        end
                        // A last word at the final address is a legal full program.
                        if (s.s_last) begin
                            r_state <= c_FINISH;
                        end else if (r_ptr == c_PTR_MAX) begin
                            r_state    <= c_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                c_FINISH: begin
                    // Final write completes this cycle; core leaves reset after it.
                    r_state   <= c_RUN;
                    cpu_rst   <= 1'b0;
                    load_done <= 1'b1;
                end
                c_RUN, c_ERROR: begin
                    if (start) begin
                        r_state     <= c_LOAD;
                        r_ptr       <= '0;
                        cpu_rst     <= 1'b1;
                        load_done   <= 1'b0;
                        load_error  <= 1'b0;
                        word_count  <= '0;
                        checksum    <= '0;
                        check_count <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
